// File: rtl/mode3_demux_if.sv
// mode3_demux_if: groups the TDM input side and the recovered-stream output
// side of mode3_demux into one bundle. Clock and reset stay outside.
//
// Signals:
//   enable             block enable; low forces the demux back to IDLE
//   sync               frame-start marker (high on the first DS1 word)
//   switch_clk_cycles  slot length N in clock cycles
//   in_3               TDM data word
//   DS1_out..DS3_out   recovered streams
//   ds_valid           one-cycle update strobes, bit k-1 for DSk_out
//   slot               current slot index (3 when not locked)
//   locked             high while the demux follows a frame
//   sync_err           one-cycle pulse on unexpected sync or illegal N
//   frame_cnt          completed-frame counter, only with
//                      MODE3_DEMUX_FRAME_CNT_EN defined
//
// Modports: master drives the TDM side and observes the outputs (source or
// bench); slave is the demux itself.
interface mode3_demux_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
);
  logic              enable;
  logic              sync;
  logic [CNT_W-1:0]  switch_clk_cycles;
  logic [DATA_W-1:0] in_3;
  logic [DATA_W-1:0] DS1_out;
  logic [DATA_W-1:0] DS2_out;
  logic [DATA_W-1:0] DS3_out;
  logic [2:0]        ds_valid;
  logic [1:0]        slot;
  logic              locked;
  logic              sync_err;
`ifdef MODE3_DEMUX_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  modport master (
`ifdef MODE3_DEMUX_FRAME_CNT_EN
    input  frame_cnt,
`endif
    output enable, sync, switch_clk_cycles, in_3,
    input  DS1_out, DS2_out, DS3_out, ds_valid, slot, locked, sync_err
  );

  modport slave (
`ifdef MODE3_DEMUX_FRAME_CNT_EN
    output frame_cnt,
`endif
    input  enable, sync, switch_clk_cycles, in_3,
    output DS1_out, DS2_out, DS3_out, ds_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/mode3_demux.sv
// mode3_demux: receive-side three-stream TDM demultiplexer.
// A 16-bit TDM stream made of frames of three N-cycle slots (DS1, DS2, DS3)
// is split back into three registered outputs. Each output is updated one
// cycle after the last word of its slot, together with a ds_valid strobe.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mode3_demux_if.slave (enable, sync, switch_clk_cycles, in_3 in;
//          DS1_out, DS2_out, DS3_out, ds_valid, slot, locked, sync_err out)
//
// Optional feature: define MODE3_DEMUX_FRAME_CNT_EN to add bus.frame_cnt,
// a 16-bit count of completed frames that is cleared on a sync_err resync.
module mode3_demux #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input logic          clk,
  input logic          rst_n,
  mode3_demux_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [1:0]        slot_q, slot_d;
  logic [DATA_W-1:0] ds1_q, ds1_d;
  logic [DATA_W-1:0] ds2_q, ds2_d;
  logic [DATA_W-1:0] ds3_q, ds3_d;
  logic [2:0]        valid_q, valid_d;
  logic              err_q, err_d;
`ifdef MODE3_DEMUX_FRAME_CNT_EN
  logic [15:0]       frame_q, frame_d;
`endif

  // Position of the cycle being processed. Normally this is the registered
  // slot/count, but on the sync cycle that leaves IDLE it is slot 0, count 0
  // with the freshly sampled slot length.
  logic [1:0]        cur_slot;
  logic [CNT_W-1:0]  cur_cnt;
  logic [CNT_W-1:0]  cur_n;
  logic              active;
  logic              resync;
  logic              last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      slot_q  <= 2'd3;
      ds1_q   <= '0;
      ds2_q   <= '0;
      ds3_q   <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
`ifdef MODE3_DEMUX_FRAME_CNT_EN
      frame_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      slot_q  <= slot_d;
      ds1_q   <= ds1_d;
      ds2_q   <= ds2_d;
      ds3_q   <= ds3_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef MODE3_DEMUX_FRAME_CNT_EN
      frame_q <= frame_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    slot_d   = slot_q;
    ds1_d    = ds1_q;
    ds2_d    = ds2_q;
    ds3_d    = ds3_q;
    valid_d  = 3'b000;
    err_d    = 1'b0;
`ifdef MODE3_DEMUX_FRAME_CNT_EN
    frame_d  = frame_q;
`endif
    cur_slot = slot_q;
    cur_cnt  = cnt_q;
    cur_n    = n_q;
    active   = 1'b0;
    resync   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enable && bus.sync) begin
          if (bus.switch_clk_cycles == '0) begin
            err_d = 1'b1;
          end else begin
            active   = 1'b1;
            cur_slot = 2'd0;
            cur_cnt  = '0;
            cur_n    = bus.switch_clk_cycles;
          end
        end
      end
      RUN: begin
        if (!bus.enable) begin
          state_d = IDLE;
          slot_d  = 2'd3;
          cnt_d   = '0;
        end else begin
          active = 1'b1;
          // Slot 0 / count 0 is the first cycle of a frame, the only place a
          // sync is expected.
          resync = bus.sync && !(slot_q == 2'd0 && cnt_q == '0);
        end
      end
    endcase

    last = active && (cur_cnt == cur_n - CNT_W'(1));

    // The capture of a finishing slot always completes, even when a resync
    // happens on the same cycle.
    if (last) begin
      case (cur_slot)
        2'd0: begin
          ds1_d   = bus.in_3;
          valid_d = 3'b001;
        end
        2'd1: begin
          ds2_d   = bus.in_3;
          valid_d = 3'b010;
        end
        default: begin
          ds3_d   = bus.in_3;
          valid_d = 3'b100;
`ifdef MODE3_DEMUX_FRAME_CNT_EN
          frame_d = frame_q + 16'd1;
`endif
        end
      endcase
    end

    if (active) begin
      state_d = RUN;
      n_d     = cur_n;
      if (resync) begin
        // The unexpected sync cycle itself becomes slot 0, count 0.
        err_d = 1'b1;
        n_d   = bus.switch_clk_cycles;
`ifdef MODE3_DEMUX_FRAME_CNT_EN
        frame_d = '0;
`endif
        if (bus.switch_clk_cycles == '0) begin
          state_d = IDLE;
          slot_d  = 2'd3;
          cnt_d   = '0;
        end else if (bus.switch_clk_cycles == CNT_W'(1)) begin
          slot_d = 2'd1;
          cnt_d  = '0;
        end else begin
          slot_d = 2'd0;
          cnt_d  = CNT_W'(1);
        end
      end else if (last) begin
        cnt_d = '0;
        if (cur_slot == 2'd2) begin
          // Frame boundary: slot length changes only take effect here.
          slot_d = 2'd0;
          n_d    = bus.switch_clk_cycles;
          if (bus.switch_clk_cycles == '0) begin
            state_d = IDLE;
            slot_d  = 2'd3;
            err_d   = 1'b1;
          end
        end else begin
          slot_d = cur_slot + 2'd1;
        end
      end else begin
        slot_d = cur_slot;
        cnt_d  = cur_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.DS1_out  = ds1_q;
  assign bus.DS2_out  = ds2_q;
  assign bus.DS3_out  = ds3_q;
  assign bus.ds_valid = valid_q;
  assign bus.slot     = slot_q;
  assign bus.locked   = (state_q == RUN);
  assign bus.sync_err = err_q;
`ifdef MODE3_DEMUX_FRAME_CNT_EN
  assign bus.frame_cnt = frame_q;
`endif

endmodule

// File: tb/tb_mode3_demux.sv
// tb_mode3_demux: self-checking bench for mode3_demux.
// A frame-offset model (position = (cycle - frame_start) / N) predicts every
// output; it is compared against the DUT each cycle, and a set of literal
// expectations pins the model on the key scenarios.
module tb_mode3_demux;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  mode3_demux_if bus ();

  mode3_demux dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic        m_locked;
  int          m_t0;
  int          m_n;
  logic [15:0] m_ds1, m_ds2, m_ds3, m_frames;
  logic [2:0]  m_valid;
  logic        m_err;
  logic [1:0]  m_slot;
  int          cyc;

  // Behavioural model: a frame starts at cycle m_t0, so the position of any
  // cycle is plain division of its offset by N.
  always @(posedge clk or negedge rst_n) begin : model
    logic        lk;
    logic        run_cycle;
    int          t0, n, off, k;
    logic [15:0] d1, d2, d3, fr;
    logic [2:0]  vl;
    logic        er;
    if (!rst_n) begin
      m_locked <= 1'b0;
      m_t0     <= 0;
      m_n      <= 0;
      m_ds1    <= '0;
      m_ds2    <= '0;
      m_ds3    <= '0;
      m_frames <= '0;
      m_valid  <= '0;
      m_err    <= 1'b0;
      m_slot   <= 2'd3;
      cyc      <= 0;
    end else begin
      lk = m_locked; t0 = m_t0; n = m_n;
      d1 = m_ds1; d2 = m_ds2; d3 = m_ds3; fr = m_frames;
      vl = 3'b000; er = 1'b0; run_cycle = 1'b0;
      if (lk && !bus.enable) begin
        lk = 1'b0;
      end else if (lk) begin
        run_cycle = 1'b1;
      end else if (bus.enable && bus.sync) begin
        if (bus.switch_clk_cycles == 0) er = 1'b1;
        else begin
          lk = 1'b1; t0 = cyc; n = int'(bus.switch_clk_cycles);
          run_cycle = 1'b1;
        end
      end
      if (run_cycle) begin
        off = cyc - t0;
        k   = off / n;
        if (off % n == n - 1) begin
          if (k == 0) d1 = bus.in_3;
          else if (k == 1) d2 = bus.in_3;
          else begin d3 = bus.in_3; fr = fr + 16'd1; end
          vl[k] = 1'b1;
        end
        if (bus.sync && off != 0) begin
          er = 1'b1; fr = '0;
          if (bus.switch_clk_cycles == 0) lk = 1'b0;
          else begin t0 = cyc; n = int'(bus.switch_clk_cycles); end
        end else if (off == 3 * n - 1) begin
          if (bus.switch_clk_cycles == 0) begin lk = 1'b0; er = 1'b1; end
          else begin t0 = cyc + 1; n = int'(bus.switch_clk_cycles); end
        end
      end
      m_locked <= lk;
      m_t0     <= t0;
      m_n      <= n;
      m_ds1    <= d1;
      m_ds2    <= d2;
      m_ds3    <= d3;
      m_frames <= fr;
      m_valid  <= vl;
      m_err    <= er;
      m_slot   <= lk ? 2'((cyc + 1 - t0) / n) : 2'd3;
      cyc      <= cyc + 1;
    end
  end

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Whole-output comparison against the model
  task automatic compareModel();
    checkOutput("ds1", 32'(bus.DS1_out), 32'(m_ds1));
    checkOutput("ds2", 32'(bus.DS2_out), 32'(m_ds2));
    checkOutput("ds3", 32'(bus.DS3_out), 32'(m_ds3));
    checkOutput("ds_valid", 32'(bus.ds_valid), 32'(m_valid));
    checkOutput("slot", 32'(bus.slot), 32'(m_slot));
    checkOutput("locked", 32'(bus.locked), 32'(m_locked));
    checkOutput("sync_err", 32'(bus.sync_err), 32'(m_err));
`ifdef MODE3_DEMUX_FRAME_CNT_EN
    checkOutput("frame_cnt", 32'(bus.frame_cnt), 32'(m_frames));
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, then compare after the
  // following rising edge has been processed
  task automatic applyStimulus(input logic en, input logic sy, input logic [31:0] n, input logic [15:0] d);
    bus.enable            = en;
    bus.sync              = sy;
    bus.switch_clk_cycles = n;
    bus.in_3              = d;
    @(posedge clk);
    @(negedge clk);
    compareModel();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.sync = 1'b0;
    bus.switch_clk_cycles = '0;
    bus.in_3 = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_slot", 32'(bus.slot), 32'd3);
    checkOutput("reset_locked", 32'(bus.locked), 32'd0);
    checkOutput("reset_ds1", 32'(bus.DS1_out), 32'd0);
    rst_n = 1'b1;

    // N=4, sync at cycle 0, data = cycle index
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, i == 0, 32'd4, 16'(i));
      if (i == 0)  checkOutput("t1_locked", 32'(bus.locked), 32'd1);
      if (i == 3)  checkOutput("t1_ds1", 32'(bus.DS1_out), 32'd3);
      if (i == 3)  checkOutput("t1_v1", 32'(bus.ds_valid), 32'b001);
      if (i == 7)  checkOutput("t1_ds2", 32'(bus.DS2_out), 32'd7);
      if (i == 7)  checkOutput("t1_v2", 32'(bus.ds_valid), 32'b010);
      if (i == 11) checkOutput("t1_ds3", 32'(bus.DS3_out), 32'd11);
      if (i == 11) checkOutput("t1_v3", 32'(bus.ds_valid), 32'b100);
      if (i == 23) checkOutput("t1_ds3_frame2", 32'(bus.DS3_out), 32'd23);
    end

    // Disable mid-frame, then N=1 stream A..F
    applyStimulus(1'b0, 1'b0, 32'd1, 16'h0);
    checkOutput("dis_slot", 32'(bus.slot), 32'd3);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, i == 0, 32'd1, 16'(16'hA0 + i));
      if (i == 0) checkOutput("t2_dsA", 32'(bus.DS1_out), 32'hA0);
      if (i == 1) checkOutput("t2_dsB", 32'(bus.DS2_out), 32'hA1);
      if (i == 2) checkOutput("t2_dsC", 32'(bus.DS3_out), 32'hA2);
      if (i == 4) checkOutput("t2_dsE", 32'(bus.DS2_out), 32'hA4);
      if (i == 4) checkOutput("t2_vE", 32'(bus.ds_valid), 32'b010);
    end

    // N=4 then reconfigured to 2 mid-frame
    applyStimulus(1'b0, 1'b0, 32'd4, 16'h0);
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, i == 0, (i < 5) ? 32'd4 : 32'd2, 16'(16'h100 + i));
      if (i == 11) checkOutput("t3_ds3_old", 32'(bus.DS3_out), 32'h10B);
      if (i == 13) checkOutput("t3_ds1_new", 32'(bus.DS1_out), 32'h10D);
      if (i == 17) checkOutput("t3_v3_new", 32'(bus.ds_valid), 32'b100);
    end

    // Unexpected syncs at 6 and 9 (the latter on a capture), expected at 21
    applyStimulus(1'b0, 1'b0, 32'd4, 16'h0);
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, (i == 0) || (i == 6) || (i == 9) || (i == 21), 32'd4, 16'(16'h200 + i));
      if (i == 6)  checkOutput("t4_err", 32'(bus.sync_err), 32'd1);
      if (i == 6)  checkOutput("t4_noval", 32'(bus.ds_valid), 32'b000);
      if (i == 9)  checkOutput("t4_ds1", 32'(bus.DS1_out), 32'h209);
      if (i == 9)  checkOutput("t4_err2", 32'(bus.sync_err), 32'd1);
      if (i == 12) checkOutput("t4_ds1_resync", 32'(bus.DS1_out), 32'h20C);
      if (i == 21) checkOutput("t4_expected", 32'(bus.sync_err), 32'd0);
    end

    // Illegal N at sync, then async reset mid-frame at N=5
    applyStimulus(1'b0, 1'b0, 32'd0, 16'h0);
    applyStimulus(1'b1, 1'b1, 32'd0, 16'h0);
    checkOutput("t5_err", 32'(bus.sync_err), 32'd1);
    checkOutput("t5_unlocked", 32'(bus.locked), 32'd0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, i == 0, 32'd5, 16'(16'h300 + i));
      if (i == 4) checkOutput("t5_ds1", 32'(bus.DS1_out), 32'h304);
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_ds1", 32'(bus.DS1_out), 32'd0);
    checkOutput("t5_rst_ds3", 32'(bus.DS3_out), 32'd0);
    checkOutput("t5_rst_slot", 32'(bus.slot), 32'd3);
    checkOutput("t5_rst_locked", 32'(bus.locked), 32'd0);
    compareModel();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd5, 16'h55);

    // N=2: three full frames, then an unexpected sync
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b1, (i == 0) || (i == 19), 32'd2, 16'(16'h400 + i));
      if (i == 17) checkOutput("t6_ds3", 32'(bus.DS3_out), 32'h411);
      if (i == 19) checkOutput("t6_err", 32'(bus.sync_err), 32'd1);
`ifdef MODE3_DEMUX_FRAME_CNT_EN
      if (i == 17) checkOutput("t6_frames", 32'(bus.frame_cnt), 32'd3);
      if (i == 19) checkOutput("t6_frames_clr", 32'(bus.frame_cnt), 32'd0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mode3_demux.md
Name: mode3_demux

Overview:
- Receive-side counterpart of the three-stream time-division multiplexer.
- Takes a single 16-bit TDM stream built from repeating frames of three equal-length slots (DS1, DS2, DS3). Frame start is marked by a sync pulse.
- Recovers the three streams into separate registered outputs, each with a one-cycle valid strobe per frame.
- Sits at the far end of the link, feeding per-stream consumers.

Parameters:
- DATA_W, 16: width of the TDM word and each recovered stream.
- CNT_W, 32: width of the slot-length configuration and the internal cycle counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  when low, the block returns to IDLE on the next edge; outputs hold.
- sync  input  1  frame-start marker; high on the cycle carrying the first DS1 word.
- switch_clk_cycles  input  CNT_W  slot length N in clk cycles.
- in_3  input  DATA_W  TDM data word.
- DS1_out  output  DATA_W  recovered stream 1.
- DS2_out  output  DATA_W  recovered stream 2.
- DS3_out  output  DATA_W  recovered stream 3.
- ds_valid  output  3  one-cycle strobes; bit k-1 means DSk_out was updated this cycle.
- slot  output  2  current slot index: 0, 1 or 2; 3 when not locked.
- locked  output  1  high while in RUN.
- sync_err  output  1  one-cycle pulse on an unexpected sync or an illegal N.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0, slot=3, DSk_out=0, ds_valid=0, locked=0, sync_err=0, latched N=0.
- States: IDLE, RUN.
- IDLE:
  - Waits for sync with enable high.
  - On that cycle: latch N_l = switch_clk_cycles. Treat that cycle as slot 0, count 0. Go to RUN with cnt=1 (or cnt=0, slot=1 if N_l=1).
  - If switch_clk_cycles=0 at sync: stay in IDLE and pulse sync_err.
- RUN:
  - cnt counts 0..N_l-1 within each slot; slot advances 0->1->2->0.
  - When slot wraps 2->0, N_l is re-latched from switch_clk_cycles, so configuration changes take effect only at frame boundaries.
  - If the new value is 0: go to IDLE and pulse sync_err.
- Capture:
  - On the last cycle of slot k (cnt==N_l-1), in_3 is registered into DS(k+1)_out.
  - ds_valid[k] is high the following cycle, coincident with the new data.
  - Latency from the last slot word to its appearance on the output: 1 cycle.
  - Outputs hold between updates.
- Frame length is 3*N_l cycles. With N_l=1, every cycle is a capture and ds_valid rotates 001, 010, 100.
- Expected sync: the cycle after slot 2's last cycle (first cycle of the next frame). sync there is accepted silently; sync absent there is also legal (free-run).
- Unexpected sync (any other RUN cycle):
  - Pulse sync_err the next cycle.
  - Resynchronise: that cycle becomes slot 0, count 0, N_l re-latched.
  - No ds_valid is generated for the truncated slot.
- sync and a slot-end capture on the same cycle: the capture completes first, then resync.
- enable low in RUN: go to IDLE next edge. No further captures, locked=0, slot=3.
- Reset mid-frame: immediate return to reset values; the next frame needs a fresh sync.
- Counter comparisons are unsigned, CNT_W wide. N_l up to 2^CNT_W-1 is legal; no overflow occurs because cnt never exceeds N_l-1.

Optional Feature:
- Macro: MODE3_DEMUX_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0], reset 0.
  - Increments the cycle ds_valid[2] is asserted; wraps 0xFFFF->0.
  - Cleared on resync caused by sync_err.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- N=4; sync at cycle 0; in_3 = cycle index.
  - DS1_out=3 with ds_valid=001 at cycle 4.
  - DS2_out=7 / 010 at cycle 8.
  - DS3_out=11 / 100 at cycle 12.
  - Repeats every 12 cycles with no sync_err.
- N=1; sync then stream A,B,C,D,E,F -> DS1=A, DS2=B, DS3=C on successive cycles, then D, E, F; ds_valid rotates 001,010,100.
- N=4 locked; switch_clk_cycles changed to 2 mid-frame -> current frame stays 12 cycles; next frame uses 6-cycle frames.
- N=4 locked; sync at cycle 6 (slot 1, cnt 2) -> sync_err at cycle 7; DS2_out not updated; DS1 next captured at cycle 10.
- switch_clk_cycles=0 with sync in IDLE -> sync_err pulse, locked stays 0. Then rst_n low mid-frame at N=5 -> all outputs 0 and slot=3 immediately, without waiting for a clock edge.
- With MODE3_DEMUX_FRAME_CNT_EN: 3 frames at N=2 -> frame_cnt=3. Then an unexpected sync -> frame_cnt=0.
